// File: rtl/cpu_sequencer.sv
// T-state microsequencer for the board datapath: fetches an opcode, then emits one
// 32-bit control word per clock for a small fixed instruction subset.
module cpu_sequencer #(
  parameter bit         HALT_ON_ILLEGAL = 1'b1,
  parameter logic [7:0] IR_RESET        = 8'hEA
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  dataio_in,
  input  logic        rdy,
  output logic [31:0] ctl,
  output logic        rw,
  output logic        sync,
  output logic        halted,
  output logic [3:0]  tstate
);

  localparam int unsigned TW = 4;

  localparam logic [TW-1:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4,
                            T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, T8 = 4'd8, T9 = 4'd9,
                            T10 = 4'd10;

  localparam logic [7:0] OP_NOP  = 8'hEA, OP_LDA_IMM = 8'hA9, OP_LDX_IMM = 8'hA2,
                         OP_LDY_IMM = 8'hA0, OP_TAX = 8'hAA, OP_TAY = 8'hA8,
                         OP_TXA  = 8'h8A, OP_TYA = 8'h98, OP_JMP = 8'h4C,
                         OP_LDA_ABS = 8'hAD, OP_STA_ABS = 8'h8D;

  // Control word bit positions
  localparam int unsigned DLWA = 0, DLDBOA = 1, DLADLOA = 2, DLADHOA = 3, PCLADLWA = 4,
                          PCLINC = 5, PCLADLOA = 6, PCHADHWA = 8, PCHINC = 9,
                          PCHADHOA = 10, DORWA = 12, DOROA = 13, ABHWA = 14, ABLWA = 15,
                          XWA = 16, XOA = 17, YWA = 18, YOA = 19, PREDBWA = 20,
                          PREADLWA = 21, PRESBWA = 22, SUMS = 23, ALUADLOA = 24,
                          ALUSBOA = 25, ACCWA = 26, ACCSBOA = 27, ACCDBOA = 28;

  localparam logic [31:0] ONE = 32'd1;
  localparam logic [31:0] M_APC     = (ONE << PCLADLOA) | (ONE << PCHADHOA) |
                                      (ONE << ABHWA) | (ONE << ABLWA);
  localparam logic [31:0] M_RDI     = (ONE << DLWA) | (ONE << PCLINC);
  localparam logic [31:0] M_LOAD    = (ONE << DLDBOA) | (ONE << PREDBWA) | (ONE << PRESBWA);
  localparam logic [31:0] M_PASS    = (ONE << SUMS) | (ONE << ALUSBOA);
  localparam logic [31:0] M_ABS_LO  = (ONE << DLADLOA) | (ONE << PREADLWA) | (ONE << PRESBWA);
  localparam logic [31:0] M_JMP_T7  = (ONE << DLADHOA) | (ONE << PCHADHWA) | (ONE << SUMS) |
                                      (ONE << ALUADLOA) | (ONE << PCLADLWA);
  localparam logic [31:0] M_ABS_HI  = (ONE << DLADHOA) | (ONE << ABHWA) | (ONE << SUMS) |
                                      (ONE << ALUADLOA) | (ONE << ABLWA);
  localparam logic [31:0] M_STORE   = (ONE << ACCDBOA) | (ONE << DORWA) | (ONE << DOROA);

  logic [TW-1:0] t_q, t_d;
  logic [7:0]    ir_q, ir_d;
  logic          halted_q, halted_d;
  logic [31:0]   ctl_raw;
  logic [31:0]   ld_dst;
  logic          run;

  function automatic logic supported(input logic [7:0] op);
    case (op)
      OP_NOP, OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_TAX, OP_TAY, OP_TXA, OP_TYA,
      OP_JMP, OP_LDA_ABS, OP_STA_ABS: supported = 1'b1;
      default:                        supported = 1'b0;
    endcase
  endfunction

  function automatic logic [TW-1:0] last_t(input logic [7:0] op);
    case (op)
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: last_t = T5;
      OP_JMP:                             last_t = T7;
      OP_STA_ABS:                         last_t = T8;
      OP_LDA_ABS:                         last_t = T10;
      default:                            last_t = T2;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      t_q      <= T0;
      ir_q     <= IR_RESET;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Next T-state: fetch, dispatch after T1, wrap to T0 after the opcode's last T-state
  always_comb begin
    t_d      = t_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    if (rdy && !halted_q) begin
      if (t_q == T0) begin
        t_d = T1;
      end else if (t_q == T1) begin
        ir_d = dataio_in;
        if (HALT_ON_ILLEGAL && !supported(dataio_in)) begin
          halted_d = 1'b1;
          t_d      = T0;
        end else begin
          t_d = T2;
        end
      end else if (t_q >= last_t(ir_q)) begin
        t_d = T0;
      end else begin
        t_d = TW'(t_q + 4'd1);
      end
    end
  end

  always_comb begin
    ld_dst = ONE << ACCWA;
    if (ir_q == OP_LDX_IMM) ld_dst = ONE << XWA;
    if (ir_q == OP_LDY_IMM) ld_dst = ONE << YWA;
  end

  // Raw control word for the current T-state/IR pair; unreachable pairs stay zero
  always_comb begin
    ctl_raw = '0;
    if (t_q == T0) begin
      ctl_raw = M_APC;
    end else if (t_q == T1) begin
      ctl_raw = M_RDI;
    end else begin
      case (ir_q)
        OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: begin
          case (t_q)
            T2:      ctl_raw = M_APC;
            T3:      ctl_raw = M_RDI;
            T4:      ctl_raw = M_LOAD;
            T5:      ctl_raw = M_PASS | ld_dst;
            default: ctl_raw = '0;
          endcase
        end
        OP_TAX: if (t_q == T2) ctl_raw = (ONE << ACCSBOA) | (ONE << XWA);
        OP_TAY: if (t_q == T2) ctl_raw = (ONE << ACCSBOA) | (ONE << YWA);
        OP_TXA: if (t_q == T2) ctl_raw = (ONE << XOA) | (ONE << ACCWA);
        OP_TYA: if (t_q == T2) ctl_raw = (ONE << YOA) | (ONE << ACCWA);
        OP_JMP, OP_LDA_ABS, OP_STA_ABS: begin
          case (t_q)
            T2:      ctl_raw = M_APC;
            T3:      ctl_raw = M_RDI;
            T4:      ctl_raw = M_ABS_LO;
            T5:      ctl_raw = M_APC;
            T6:      ctl_raw = M_RDI;
            T7:      ctl_raw = (ir_q == OP_JMP) ? M_JMP_T7 : M_ABS_HI;
            T8: begin
              if (ir_q == OP_LDA_ABS) ctl_raw = ONE << DLWA;
              if (ir_q == OP_STA_ABS) ctl_raw = M_STORE;
            end
            T9:      if (ir_q == OP_LDA_ABS) ctl_raw = M_LOAD;
            T10:     if (ir_q == OP_LDA_ABS) ctl_raw = M_PASS | (ONE << ACCWA);
            default: ctl_raw = '0;
          endcase
        end
        default: ctl_raw = '0;
      endcase
    end
  end

  // Strobes are gated by reset, stall and halt so no partial word reaches the board
  assign run    = clr && rdy && !halted_q;
  assign ctl    = run ? ctl_raw : '0;
  assign rw     = !(run && ir_q == OP_STA_ABS && t_q == T8);
  assign sync   = clr && !halted_q && (t_q == T0);
  assign halted = halted_q;
  assign tstate = t_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: two instances (halt / NOP on illegal opcode) are
// checked each cycle against per-instruction control-word lists built from the opcode table.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        rdy;
  logic [7:0]  din;
  logic [31:0] ctl_h, ctl_n;
  logic        rw_h, rw_n, sync_h, sync_n, halt_h, halt_n;
  logic [3:0]  t_h, t_n;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.HALT_ON_ILLEGAL(1'b1), .IR_RESET(8'hEA)) dut_h (
    .clk(clk), .clr(clr), .dataio_in(din), .rdy(rdy),
    .ctl(ctl_h), .rw(rw_h), .sync(sync_h), .halted(halt_h), .tstate(t_h));

  cpu_sequencer #(.HALT_ON_ILLEGAL(1'b0), .IR_RESET(8'hEA)) dut_n (
    .clk(clk), .clr(clr), .dataio_in(din), .rdy(rdy),
    .ctl(ctl_n), .rw(rw_n), .sync(sync_n), .halted(halt_n), .tstate(t_n));

  function automatic logic [31:0] b(input int i);
    return 32'd1 << i;
  endfunction

  localparam logic [7:0] LEGAL [11] = '{8'hEA, 8'hA9, 8'hA2, 8'hA0, 8'hAA, 8'hA8,
                                        8'h8A, 8'h98, 8'h4C, 8'hAD, 8'h8D};

  logic [31:0] exp_q[$];
  int          exp_wr;

  function automatic bit is_legal(input logic [7:0] op);
    foreach (LEGAL[k]) if (LEGAL[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected control word per cycle of one instruction, straight from the opcode table
  function automatic void build(input logic [7:0] op);
    logic [31:0] apc, rdi, load, pass, abs_lo, abs_hi;
    apc    = b(6) | b(10) | b(14) | b(15);
    rdi    = b(0) | b(5);
    load   = b(1) | b(20) | b(22);
    pass   = b(23) | b(25);
    abs_lo = b(2) | b(21) | b(22);
    abs_hi = b(3) | b(14) | b(23) | b(24) | b(15);
    exp_q.delete();
    exp_wr = -1;
    exp_q.push_back(apc);
    exp_q.push_back(rdi);
    case (op)
      8'hA9, 8'hA2, 8'hA0: begin
        exp_q.push_back(apc); exp_q.push_back(rdi); exp_q.push_back(load);
        exp_q.push_back(pass | ((op == 8'hA9) ? b(26) : (op == 8'hA2) ? b(16) : b(18)));
      end
      8'hAA: exp_q.push_back(b(27) | b(16));
      8'hA8: exp_q.push_back(b(27) | b(18));
      8'h8A: exp_q.push_back(b(17) | b(26));
      8'h98: exp_q.push_back(b(19) | b(26));
      8'h4C, 8'hAD, 8'h8D: begin
        exp_q.push_back(apc); exp_q.push_back(rdi); exp_q.push_back(abs_lo);
        exp_q.push_back(apc); exp_q.push_back(rdi);
        if (op == 8'h4C) exp_q.push_back(b(3) | b(8) | b(23) | b(24) | b(4));
        else exp_q.push_back(abs_hi);
        if (op == 8'hAD) begin
          exp_q.push_back(b(0)); exp_q.push_back(load); exp_q.push_back(pass | b(26));
        end
        if (op == 8'h8D) begin
          exp_q.push_back(b(28) | b(12) | b(13));
          exp_wr = 8;
        end
      end
      default: exp_q.push_back(32'h0);
    endcase
  endfunction

  // One cycle of a legal instruction: drive, settle, compare both instances, optionally clock
  task automatic drive_check(input bit r, input int i, input logic [7:0] op, input bit adv);
    logic [38:0] expv;
    rdy = r;
    din = (i == 1) ? op : 8'($urandom);
    #1;
    expv = {r ? exp_q[i] : 32'h0, (r && i == exp_wr) ? 1'b0 : 1'b1, 1'(i == 0), 1'b0, 4'(i)};
    vectors++;
    if ({ctl_h, rw_h, sync_h, halt_h, t_h} !== expv) begin
      errors++;
      $display("FAIL seq_h op=%h T%0d rdy=%0d got ctl/rw/sync/halt/t=%h expected %h",
               op, i, r, {ctl_h, rw_h, sync_h, halt_h, t_h}, expv);
    end
    vectors++;
    if ({ctl_n, rw_n, sync_n, halt_n, t_n} !== expv) begin
      errors++;
      $display("FAIL seq_n op=%h T%0d rdy=%0d got ctl/rw/sync/halt/t=%h expected %h",
               op, i, r, {ctl_n, rw_n, sync_n, halt_n, t_n}, expv);
    end
    if (adv) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [7:0] op, input int stall_at, input int stall_len,
                           input int stall_pct);
    int n;
    build(op);
    for (int i = 0; i < exp_q.size(); i++) begin
      n = (i == stall_at) ? stall_len : 0;
      if (stall_pct > 0 && $urandom_range(99) < stall_pct) n += $urandom_range(2, 1);
      for (int s = 0; s < n; s++) drive_check(1'b0, i, op, 1'b1);
      drive_check(1'b1, i, op, 1'b1);
    end
  endtask

  task automatic check_in_reset(input string tag);
    vectors++;
    if ({ctl_h, rw_h, sync_h, halt_h, t_h} !== {32'h0, 1'b1, 1'b0, 1'b0, 4'd0} ||
        {ctl_n, rw_n, sync_n, halt_n, t_n} !== {32'h0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL %s got h=%h n=%h expected ctl=0 rw=1 sync=0 halt=0 t=0", tag,
               {ctl_h, rw_h, sync_h, halt_h, t_h}, {ctl_n, rw_n, sync_n, halt_n, t_n});
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0; rdy = 1'b1; din = 8'h00;
    #3;
    check_in_reset("reset_initial");
    repeat (2) @(posedge clk);
    #2;
    check_in_reset("reset_clocked");
    release_reset();
    run_instr(8'hEA, -1, 0, 0);
  endtask

  task automatic test_lda_imm();
    run_instr(8'hA9, -1, 0, 0);
    run_instr(8'hEA, -1, 0, 0);
  endtask

  task automatic test_sta();
    run_instr(8'h8D, -1, 0, 0);
    run_instr(8'hAA, -1, 0, 0);
  endtask

  task automatic test_jmp();
    run_instr(8'h4C, -1, 0, 0);
    run_instr(8'h8A, -1, 0, 0);
  endtask

  task automatic test_stall_ldx();
    run_instr(8'hA2, 3, 3, 0);
    run_instr(8'hA8, -1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) run_instr(LEGAL[$urandom_range(10)], -1, 0, 25);
  endtask

  // Pull clr low in the middle of T8 and expect strobes to drop immediately
  task automatic test_abort(input logic [7:0] op);
    build(op);
    for (int i = 0; i < 8; i++) drive_check(1'b1, i, op, 1'b1);
    drive_check(1'b1, 8, op, 1'b0);
    #2;
    clr = 1'b0;
    #1;
    check_in_reset("abort_mid_T8");
    repeat (2) @(posedge clk);
    release_reset();
    run_instr(8'hA0, -1, 0, 0);
  endtask

  task automatic test_illegal(input logic [7:0] op_in);
    logic [7:0] op;
    op = op_in;
    while (is_legal(op)) op = 8'($urandom);
    build(op);
    drive_check(1'b1, 0, op, 1'b1);
    drive_check(1'b1, 1, op, 1'b1);
    rdy = 1'b1; din = 8'($urandom);
    #1;
    vectors++;
    if ({ctl_n, rw_n, sync_n, halt_n, t_n} !== {32'h0, 1'b1, 1'b0, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL illegal_nop op=%h got %h expected ctl=0 rw=1 sync=0 halt=0 t=2",
               op, {ctl_n, rw_n, sync_n, halt_n, t_n});
    end
    @(posedge clk); #1;
    rdy = 1'($urandom);
    #1;
    vectors++;
    if (sync_n !== 1'b1 || t_n !== 4'd0 || ctl_n !== (rdy ? 32'h0000C440 : 32'h0)) begin
      errors++;
      $display("FAIL illegal_nop_next op=%h got sync=%b t=%0d ctl=%h", op, sync_n, t_n, ctl_n);
    end
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if ({ctl_h, rw_h, sync_h, halt_h} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL halted op=%h cyc=%0d got ctl=%h rw=%b sync=%b halted=%b expected 0/1/0/1",
                 op, c, ctl_h, rw_h, sync_h, halt_h);
      end
      @(posedge clk); #1;
      rdy = 1'($urandom);
      din = 8'($urandom);
      #1;
    end
    clr = 1'b0;
    #1;
    check_in_reset("halt_cleared");
    release_reset();
    run_instr(8'h98, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_lda_imm();
    test_sta();
    test_jmp();
    test_stall_ldx();
    test_back_to_back();
    test_abort(8'hAD);
    test_abort(8'h8D);
    test_illegal(8'h02);
    for (int k = 0; k < 3; k++) test_illegal(8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
